// File: rtl/arb_pkg.sv
// Shared types and constants for the dual-core memory arbiter.
package arb_pkg;

   localparam int NUM_CORES = 2;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_RD
   } state_t;

   typedef logic owner_t;

   // One-hot core mask for a core index.
   function automatic logic [NUM_CORES-1:0] owner_onehot(input owner_t o);
      return o ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/dual_core_mem_arbiter_rr_select.sv
// Combinational two-way round-robin selector: a lone requester always wins,
// a tie is broken in favour of the core named by rr.
module rr_select
   import arb_pkg::*;
(
   input  logic [1:0] req,
   input  owner_t     rr,
   output logic [1:0] gnt
);

   // Pick the winner; only a tie consults the round-robin pointer.
   always_comb begin
      gnt = 2'b00;
      if (req == 2'b11) begin
         gnt = owner_onehot(rr);
      end else begin
         gnt = req;
      end
   end

endmodule

// File: rtl/dual_core_mem_arbiter.sv
// Two-core arbiter in front of a single memory port, one transaction in flight.
// Optional macro ARB_PERF_CNT_EN adds saturating grant/conflict counters.
module dual_core_mem_arbiter
   import arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [1:0]                core_req,
   input  logic [1:0]                core_we,
   input  logic [2*ADDR_W-1:0]       core_addr,
   input  logic [2*DATA_W-1:0]       core_wdata,
   input  logic [2*(DATA_W/8)-1:0]   core_be,
   output logic [1:0]                core_gnt,
   output logic [1:0]                core_rvalid,
   output logic [DATA_W-1:0]         core_rdata,
   output logic                      mem_req,
   output logic                      mem_we,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   output logic [(DATA_W/8)-1:0]     mem_be,
   input  logic                      mem_ready,
   input  logic                      mem_rvalid,
   input  logic [DATA_W-1:0]         mem_rdata
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0]               perf_gnt0,
   output logic [31:0]               perf_gnt1,
   output logic [31:0]               perf_conflict
`endif
);

   localparam int BE_W = DATA_W / 8;

   state_t              state;
   state_t              state_next;
   owner_t              rr;
   owner_t              owner;
   logic [1:0]          sel_gnt;
   logic                win;
   logic                wr_done;
   logic                rd_done;
   logic                lat_we;
   logic [ADDR_W-1:0]   lat_addr;
   logic [DATA_W-1:0]   lat_wdata;
   logic [BE_W-1:0]     lat_be;

   rr_select u_rr_select (
      .req (core_req),
      .rr  (rr),
      .gnt (sel_gnt)
   );

   assign win       = sel_gnt[1];
   assign mem_we    = lat_we;
   assign mem_addr  = lat_addr;
   assign mem_wdata = lat_wdata;
   assign mem_be    = lat_be;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state, grant pulse, memory request and completion strobes.
   always_comb begin
      state_next = state;
      core_gnt   = 2'b00;
      mem_req    = 1'b0;
      wr_done    = 1'b0;
      rd_done    = 1'b0;
      if (!rst) begin
         unique case (state)
            IDLE: begin
               if (|core_req) begin
                  core_gnt   = sel_gnt;
                  state_next = ISSUE;
               end
            end
            ISSUE: begin
               mem_req = 1'b1;
               if (mem_ready) begin
                  if (lat_we) begin
                     wr_done    = 1'b1;
                     state_next = IDLE;
                  end else begin
                     state_next = WAIT_RD;
                  end
               end
            end
            WAIT_RD: begin
               if (mem_rvalid) begin
                  rd_done    = 1'b1;
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Latch the winner's request, advance rr, and register completions.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr          <= 1'b0;
         owner       <= 1'b0;
         lat_we      <= 1'b0;
         lat_addr    <= '0;
         lat_wdata   <= '0;
         lat_be      <= '0;
         core_rvalid <= 2'b00;
         core_rdata  <= '0;
      end else begin
         if (|core_gnt) begin
            owner     <= win;
            rr        <= ~win;
            lat_we    <= win ? core_we[1] : core_we[0];
            lat_addr  <= win ? core_addr[2*ADDR_W-1:ADDR_W] : core_addr[ADDR_W-1:0];
            lat_wdata <= win ? core_wdata[2*DATA_W-1:DATA_W] : core_wdata[DATA_W-1:0];
            lat_be    <= win ? core_be[2*BE_W-1:BE_W] : core_be[BE_W-1:0];
         end
         core_rvalid <= 2'b00;
         if (wr_done) begin
            core_rvalid <= owner_onehot(owner);
            core_rdata  <= '0;
         end else if (rd_done) begin
            core_rvalid <= owner_onehot(owner);
            core_rdata  <= mem_rdata;
         end
      end
   end

`ifdef ARB_PERF_CNT_EN
   // Saturating per-core grant counters and IDLE-cycle conflict counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_gnt0     <= '0;
         perf_gnt1     <= '0;
         perf_conflict <= '0;
      end else begin
         if (core_gnt[0] && (perf_gnt0 != '1)) begin
            perf_gnt0 <= perf_gnt0 + 32'd1;
         end
         if (core_gnt[1] && (perf_gnt1 != '1)) begin
            perf_gnt1 <= perf_gnt1 + 32'd1;
         end
         if ((state == IDLE) && (core_req == 2'b11) && (perf_conflict != '1)) begin
            perf_conflict <= perf_conflict + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dual_core_mem_arbiter.sv
// Directed self-checking bench for dual_core_mem_arbiter.
// Perf counter checks are included when ARB_PERF_CNT_EN is defined.
module tb_dual_core_mem_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int BE_W   = DATA_W / 8;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [1:0]             core_req;
   logic [1:0]             core_we;
   logic [2*ADDR_W-1:0]    core_addr;
   logic [2*DATA_W-1:0]    core_wdata;
   logic [2*BE_W-1:0]      core_be;
   logic [1:0]             core_gnt;
   logic [1:0]             core_rvalid;
   logic [DATA_W-1:0]      core_rdata;
   logic                   mem_req;
   logic                   mem_we;
   logic [ADDR_W-1:0]      mem_addr;
   logic [DATA_W-1:0]      mem_wdata;
   logic [BE_W-1:0]        mem_be;
   logic                   mem_ready;
   logic                   mem_rvalid;
   logic [DATA_W-1:0]      mem_rdata;
`ifdef ARB_PERF_CNT_EN
   logic [31:0]            perf_gnt0;
   logic [31:0]            perf_gnt1;
   logic [31:0]            perf_conflict;
`endif

   int checks   = 0;
   int failures = 0;

   dual_core_mem_arbiter #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .core_req    (core_req),
      .core_we     (core_we),
      .core_addr   (core_addr),
      .core_wdata  (core_wdata),
      .core_be     (core_be),
      .core_gnt    (core_gnt),
      .core_rvalid (core_rvalid),
      .core_rdata  (core_rdata),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_be      (mem_be),
      .mem_ready   (mem_ready),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata)
`ifdef ARB_PERF_CNT_EN
      ,
      .perf_gnt0     (perf_gnt0),
      .perf_gnt1     (perf_gnt1),
      .perf_conflict (perf_conflict)
`endif
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [1:0] req, input logic [1:0] we,
                                input logic rdy, input logic rv,
                                input logic [DATA_W-1:0] rdat);
      core_req   = req;
      core_we    = we;
      mem_ready  = rdy;
      mem_rvalid = rv;
      mem_rdata  = rdat;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
         $error("[TB] check %s did not match", tag);
      end
   endtask

   function automatic logic [1:0] altGrant(input int k);
      return ((k / 2) % 2 == 0) ? 2'b01 : 2'b10;
   endfunction

   // Directed sequence of scenarios, each step hand-computed.
   initial begin
      rst        = 1'b1;
      core_addr  = '0;
      core_wdata = '0;
      core_be    = '0;
      applyStimulus(2'b11, 2'b00, 1'b1, 1'b1, 32'h0);
      tick();
      tick();
      checkOutput("rst_gnt",    64'(core_gnt),    64'h0);
      checkOutput("rst_rvalid", 64'(core_rvalid), 64'h0);
      checkOutput("rst_rdata",  64'(core_rdata),  64'h0);
      checkOutput("rst_memreq", 64'(mem_req),     64'h0);
      checkOutput("rst_memwe",  64'(mem_we),      64'h0);
      checkOutput("rst_addr",   64'(mem_addr),    64'h0);
      checkOutput("rst_wdata",  64'(mem_wdata),   64'h0);
      checkOutput("rst_be",     64'(mem_be),      64'h0);
`ifdef ARB_PERF_CNT_EN
      checkOutput("rst_perf_conf", 64'(perf_conflict), 64'h0);
`endif

      // Core 0 read at 0x100, mem_ready in cycle 1, data in cycle 2.
      rst       = 1'b0;
      core_addr = {32'h0, 32'h100};
      applyStimulus(2'b01, 2'b00, 1'b0, 1'b0, 32'h0);
      checkOutput("rd0_gnt", 64'(core_gnt), 64'h1);
      tick();
      applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 32'h0);
      checkOutput("rd0_c1_memreq", 64'(mem_req),  64'h1);
      checkOutput("rd0_c1_addr",   64'(mem_addr), 64'h100);
      checkOutput("rd0_c1_we",     64'(mem_we),   64'h0);
      checkOutput("rd0_c1_rvalid", 64'(core_rvalid), 64'h0);
      tick();
      applyStimulus(2'b00, 2'b00, 1'b0, 1'b1, 32'hDEADBEEF);
      checkOutput("rd0_c2_memreq", 64'(mem_req),     64'h0);
      checkOutput("rd0_c2_rvalid", 64'(core_rvalid), 64'h0);
      tick();
      applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
      checkOutput("rd0_c3_rvalid", 64'(core_rvalid), 64'h1);
      checkOutput("rd0_c3_rdata",  64'(core_rdata),  64'hDEADBEEF);

      // Spurious mem_ready/mem_rvalid while IDLE change nothing.
      applyStimulus(2'b00, 2'b00, 1'b1, 1'b1, 32'h12345678);
      checkOutput("idle_spur_memreq", 64'(mem_req), 64'h0);
      tick();
      applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
      checkOutput("idle_spur_rvalid", 64'(core_rvalid), 64'h0);
      checkOutput("idle_spur_rdata",  64'(core_rdata),  64'hDEADBEEF);
      checkOutput("idle_spur_memreq2", 64'(mem_req),  64'h0);

      // Lone core 0 write with be=0 while rr points at core 1.
      core_addr  = {32'h0, 32'h300};
      core_wdata = {32'h0, 32'hA5};
      core_be    = {4'hF, 4'h0};
      applyStimulus(2'b01, 2'b01, 1'b0, 1'b0, 32'h0);
      checkOutput("be0_gnt", 64'(core_gnt), 64'h1);
      tick();
      applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 32'h0);
      checkOutput("be0_memreq", 64'(mem_req),   64'h1);
      checkOutput("be0_we",     64'(mem_we),    64'h1);
      checkOutput("be0_be",     64'(mem_be),    64'h0);
      checkOutput("be0_wdata",  64'(mem_wdata), 64'hA5);
      tick();
      applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
      checkOutput("be0_rvalid", 64'(core_rvalid), 64'h1);
      checkOutput("be0_rdata",  64'(core_rdata),  64'h0);

      // Core 1 write 0x55 to 0x200 with mem_ready held low for 3 cycles.
      core_addr  = {32'h200, 32'h0};
      core_wdata = {32'h55, 32'h0};
      core_be    = {4'hF, 4'h0};
      applyStimulus(2'b10, 2'b10, 1'b0, 1'b0, 32'h0);
      checkOutput("wr1_gnt", 64'(core_gnt), 64'h2);
      tick();
      core_addr  = {32'hFFFF0000, 32'h0};
      core_wdata = {32'h0BADF00D, 32'h0};
      for (int i = 0; i < 4; i++) begin
         applyStimulus(2'b00, 2'b00, (i == 3), 1'b0, 32'h0);
         checkOutput($sformatf("wr1_memreq_%0d", i), 64'(mem_req),   64'h1);
         checkOutput($sformatf("wr1_addr_%0d", i),   64'(mem_addr),  64'h200);
         checkOutput($sformatf("wr1_wdata_%0d", i),  64'(mem_wdata), 64'h55);
         checkOutput($sformatf("wr1_we_%0d", i),     64'(mem_we),    64'h1);
         checkOutput($sformatf("wr1_be_%0d", i),     64'(mem_be),    64'hF);
         checkOutput($sformatf("wr1_rvalid_%0d", i), 64'(core_rvalid), 64'h0);
         tick();
      end
      applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
      checkOutput("wr1_done_rvalid", 64'(core_rvalid), 64'h2);
      checkOutput("wr1_done_rdata",  64'(core_rdata),  64'h0);
      checkOutput("wr1_done_memreq", 64'(mem_req),     64'h0);

      // Lone core 1 read (rr at core 0); spurious mem_ready in WAIT_RD.
      core_addr = {32'h400, 32'h0};
      applyStimulus(2'b10, 2'b00, 1'b0, 1'b0, 32'h0);
      checkOutput("rd1_gnt", 64'(core_gnt), 64'h2);
      tick();
      applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 32'h0);
      checkOutput("rd1_memreq", 64'(mem_req),  64'h1);
      checkOutput("rd1_addr",   64'(mem_addr), 64'h400);
      tick();
      applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 32'h0);
      checkOutput("rd1_wait_memreq", 64'(mem_req),     64'h0);
      checkOutput("rd1_wait_rvalid", 64'(core_rvalid), 64'h0);
      tick();
      applyStimulus(2'b00, 2'b00, 1'b0, 1'b1, 32'hCAFEF00D);
      checkOutput("rd1_wait2_memreq", 64'(mem_req),     64'h0);
      checkOutput("rd1_wait2_rvalid", 64'(core_rvalid), 64'h0);
      tick();
      applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
      checkOutput("rd1_rvalid", 64'(core_rvalid), 64'h2);
      checkOutput("rd1_rdata",  64'(core_rdata),  64'hCAFEF00D);

      // Core 0 read, reset while in WAIT_RD, late mem_rvalid afterwards.
      core_addr = {32'h0, 32'h500};
      applyStimulus(2'b01, 2'b00, 1'b0, 1'b0, 32'h0);
      checkOutput("rstmid_gnt", 64'(core_gnt), 64'h1);
      tick();
      applyStimulus(2'b00, 2'b00, 1'b1, 1'b0, 32'h0);
      tick();
      rst = 1'b1;
      applyStimulus(2'b11, 2'b00, 1'b0, 1'b0, 32'h0);
      checkOutput("rstmid_gnt_in_rst", 64'(core_gnt), 64'h0);
      checkOutput("rstmid_memreq",     64'(mem_req),  64'h0);
      tick();
      checkOutput("rstmid_rvalid", 64'(core_rvalid), 64'h0);

      // Both cores request continuously: grants alternate from core 0.
      rst = 1'b0;
      applyStimulus(2'b11, 2'b11, 1'b1, 1'b1, 32'hBAD0BAD0);
      for (int k = 0; k < 10; k++) begin
         if (k > 0) begin
            applyStimulus(2'b11, 2'b11, 1'b1, 1'b0, 32'h0);
         end
         checkOutput($sformatf("alt_gnt_%0d", k), 64'(core_gnt),
                     (k % 2 == 0) ? 64'(altGrant(k)) : 64'h0);
         checkOutput($sformatf("alt_rvalid_%0d", k), 64'(core_rvalid),
                     (k >= 2 && k % 2 == 0) ? 64'(altGrant(k - 2)) : 64'h0);
         tick();
      end
      applyStimulus(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
      checkOutput("alt_final_rvalid", 64'(core_rvalid), 64'(altGrant(8)));
`ifdef ARB_PERF_CNT_EN
      checkOutput("perf_conflict", 64'(perf_conflict), 64'd5);
      checkOutput("perf_gnt0",     64'(perf_gnt0),     64'd3);
      checkOutput("perf_gnt1",     64'(perf_gnt1),     64'd2);
      checkOutput("perf_gnt_sum",  64'(perf_gnt0) + 64'(perf_gnt1), 64'd5);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dual_core_mem_arbiter.md
DUAL_CORE_MEM_ARBITER -- requirements
Module: dual_core_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32: address width.
REQ-002 The block SHALL have parameter DATA_W, default 32: data width; the byte-enable width is DATA_W/8.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port core_req, input, 2 bits: per-core request, held until granted.
REQ-006 The block SHALL have ports core_we (input, 2 bits), core_addr (input, 2xADDR_W), core_wdata (input, 2xDATA_W) and core_be (input, 2xDATA_W/8): per-core request fields.
REQ-007 The block SHALL have port core_gnt, input-accepted pulse, output, 2 bits: one-hot, one cycle.
REQ-008 The block SHALL have port core_rvalid, output, 2 bits: one-hot completion pulse for both reads and writes.
REQ-009 The block SHALL have port core_rdata, output, DATA_W: read data, qualified by core_rvalid.
REQ-010 The block SHALL have ports mem_req, mem_we, mem_addr, mem_wdata and mem_be, all outputs: the shared memory request.
REQ-011 The block SHALL have ports mem_ready (input, 1 bit: request accepted), mem_rvalid (input, 1 bit) and mem_rdata (input, DATA_W): the memory response.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, ISSUE and WAIT_RD.
REQ-013 In IDLE with any core_req set, the block SHALL select the winner, latch its fields and owner, pulse the winner's core_gnt in that same cycle, and go to ISSUE.
REQ-014 When both cores request, the winner SHALL be the core named by the round-robin pointer rr; the loser keeps core_req asserted and is not granted that cycle.
REQ-015 rr SHALL point to the non-winning core after every grant; a lone requester SHALL be granted regardless of rr.
REQ-016 In ISSUE, the block SHALL drive mem_req=1 with the latched fields, held stable until mem_ready=1.
REQ-017 On mem_ready in ISSUE with a write, the block SHALL go to IDLE and pulse core_rvalid[owner] the next cycle with core_rdata=0.
REQ-018 On mem_ready in ISSUE with a read, the block SHALL go to WAIT_RD.
REQ-019 On mem_rvalid in WAIT_RD, the block SHALL register mem_rdata, pulse core_rvalid[owner] with that data the next cycle, and go to IDLE.
REQ-020 Minimum latency from grant (cycle 0) SHALL be: mem_req in cycle 1, write completion in cycle 2, read completion in cycle 3 when mem_rvalid arrives in cycle 2.
REQ-021 A new grant MAY occur in the same cycle as the previous transaction's core_rvalid pulse.
REQ-022 mem_ready outside ISSUE and mem_rvalid outside WAIT_RD SHALL be ignored.
REQ-023 mem_req SHALL be 0 in IDLE and WAIT_RD; the block SHALL allow at most one outstanding transaction.
REQ-024 A write with core_be=0 SHALL be passed through unchanged.

Reset
REQ-025 While rst=1, the block SHALL drive state=IDLE, rr=0 (core 0 favoured), core_gnt=0, core_rvalid=0, core_rdata=0, mem_req=0, and mem_we, mem_addr, mem_wdata and mem_be all to 0.
REQ-026 Reset asserted mid-transaction SHALL abandon the transaction without a completion pulse; a late mem_rvalid after reset SHALL be ignored.

Configuration
REQ-027 When ARB_PERF_CNT_EN is defined, the block SHALL add outputs perf_gnt0, perf_gnt1 and perf_conflict (32 bits each).
REQ-028 perf_gnt0 and perf_gnt1 SHALL count grants per core, and perf_conflict SHALL count IDLE cycles with both core_req bits set.
REQ-029 All perf counters SHALL saturate at all-ones and reset to 0.
REQ-030 When ARB_PERF_CNT_EN is undefined, the perf ports and counters SHALL be absent, with no other change in behaviour.

Structure
REQ-031 The shared package arb_pkg SHALL hold the state enum (IDLE, ISSUE, WAIT_RD), the owner typedef (1 bit) and the NUM_CORES=2 constant.
REQ-032 The block SHALL contain one sub-module, rr_select, which is combinational: it takes req[1:0] and rr and returns a one-hot grant.

Verification
REQ-033 The bench SHALL cover: core0 read at 0x100 alone, mem_ready in cycle 1, mem_rvalid with 0xDEADBEEF in cycle 2 -> core_gnt=01 in cycle 0, core_rvalid=01 with core_rdata=0xDEADBEEF in cycle 3.
REQ-034 The bench SHALL cover: both cores request continuously after reset -> grants alternate 01, 10, 01, 10.
REQ-035 The bench SHALL cover: core1 write 0x55 to 0x200, mem_ready held 0 for 3 cycles -> mem_req and fields stable for 4 cycles, core_rvalid=10 one cycle after mem_ready.
REQ-036 The bench SHALL cover: rst asserted in WAIT_RD, then mem_rvalid arrives -> no core_rvalid pulse, state IDLE, next grant goes to core 0 when both request.
REQ-037 The bench SHALL cover: spurious mem_rvalid in IDLE and mem_ready in WAIT_RD -> no output change.
REQ-038 The bench SHALL cover, with ARB_PERF_CNT_EN defined: 10 cycles of both cores requesting -> perf_conflict equals the count of IDLE cycles and perf_gnt0+perf_gnt1 equals the total number of grants.
